ram_port_arbiter: RTL

// Two-requester arbiter/sequencer for the 4-byte register-file RAM (8 bits x 4, built from quad D flip-flops).
// - Accepts one read or write request at a time from port A or port B.
// - Round-robin arbitration between the ports.
// - Drives the RAM byte-load strobes, write data and read select as registered, glitch-free signals.
// - Returns read data to the requester with a one-cycle ack pulse.
// - Sits between the two bus masters and the RAM array; it is the only agent that drives the RAM.

---
 rtl/ram_port_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-port round-robin sequencer for the 4-byte register-file RAM
module ram_port_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   a_req,
    input  logic                   a_we,
    input  logic [ADDR_W-1:0]      a_addr,
    input  logic [DATA_W-1:0]      a_wdata,
    output logic                   a_ack,
    output logic [DATA_W-1:0]      a_rdata,
    input  logic                   b_req,
    input  logic                   b_we,
    input  logic [ADDR_W-1:0]      b_addr,
    input  logic [DATA_W-1:0]      b_wdata,
    output logic                   b_ack,
    output logic [DATA_W-1:0]      b_rdata,
    output logic [2**ADDR_W-1:0]   ram_we,
    output logic [DATA_W-1:0]      ram_wdata,
    output logic [ADDR_W-1:0]      ram_sel,
    input  logic [DATA_W-1:0]      ram_rdata,
    output logic                   busy
);
    localparam int DEPTH = 2**ADDR_W;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;   // 1 = port B
    logic              grant_q, grant_d;
    logic [DEPTH-1:0]  ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [ADDR_W-1:0] ram_sel_q, ram_sel_d;
    logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    logic              sel_b;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        ram_we_d     = ram_we_q;
        ram_wdata_d  = ram_wdata_q;
        ram_sel_d    = ram_sel_q;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        sel_b        = b_req && (!a_req || !last_grant_q);
        sel_we       = sel_b ? b_we    : a_we;
        sel_addr     = sel_b ? b_addr  : a_addr;
        sel_wdata    = sel_b ? b_wdata : a_wdata;

        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    grant_d            = sel_b;
                    last_grant_d       = sel_b;
                    ram_we_d           = '0;
                    ram_we_d[sel_addr] = sel_we;
                    ram_wdata_d        = sel_wdata;
                    ram_sel_d          = sel_addr;
                    state_d            = ACCESS;
                end
            end
            ACCESS: begin
                // RAM loads on the closing edge, so this captures the pre-write byte
                if (grant_q) begin
                    b_rdata_d = ram_rdata;
                    b_ack_d   = 1'b1;
                end else begin
                    a_rdata_d = ram_rdata;
                    a_ack_d   = 1'b1;
                end
                ram_we_d = '0;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                ram_we_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            ram_we_q     <= '0;
            ram_wdata_q  <= '0;
            ram_sel_q    <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_sel_q    <= ram_sel_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_sel   = ram_sel_q;
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign busy      = (state_q != IDLE);
endmodule
